// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command decoder and its sticky-channel timers.
// Latency: n/a (package only).
// Backpressure: n/a; the decoder consumes one byte per rx_valid strobe and cannot stall.
package uart_cmd_pkg;

    // ASCII command bytes sent by the opponent console
    localparam logic [7:0] CMD_LOST  = 8'h4C;   // 'L'
    localparam logic [7:0] CMD_READY = 8'h52;   // 'R'
    localparam logic [7:0] CMD_PAUSE = 8'h50;   // 'P'
    localparam logic [7:0] CMD_WIN   = 8'h57;   // 'W'

    // Default channel map: ch0='L', ch1='R', ch2='W', ch3='P'; only 'R' is sticky
    localparam int         DEF_N_CMD       = 4;
    localparam logic [31:0] DEF_CMD_CODES  = {CMD_PAUSE, CMD_WIN, CMD_READY, CMD_LOST};
    localparam logic [3:0] DEF_STICKY_MASK = 4'b0010;

    // Per-channel sticky state
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } sticky_state_t;

    // Down-counter width; a zero timeout still gets one bit so the port is never zero-width
    function automatic int timer_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/sticky_timer.sv
// One sticky channel: holds a level from set until clr or keep-alive expiry.
// Latency: held rises/falls one cycle after the set/clr/expiry condition.
// Backpressure: none; clr beats set/reload, reload beats expiry.
module sticky_timer
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT = 0,
    parameter int TW      = timer_width(TIMEOUT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set,
    input  logic          clr,
    input  logic          reload,
    output logic          held,
    output logic [TW-1:0] timer
);

    sticky_state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;

    // State and timer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next state: clear wins over everything, reload wins over expiry
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (set && !clr) begin
                    state_d = ST_HELD;
                    timer_d = TW'(TIMEOUT);
                end
            end
            ST_HELD: begin
                if (clr) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (reload) begin
                    timer_d = TW'(TIMEOUT);
                end else if (TIMEOUT > 0) begin
                    // timer==1 is the last held cycle; the level drops on the next edge
                    if (timer_q == TW'(1)) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign held  = (state_q == ST_HELD);
    assign timer = timer_q;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes single-byte UART commands into per-channel pulses and sticky levels.
// Latency: every output is registered and updates the cycle after rx_valid & enable.
// Backpressure: none; every accepted byte is consumed, bytes arriving with enable low are dropped.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int                 N_CMD       = DEF_N_CMD,
    parameter logic [N_CMD*8-1:0] CMD_CODES   = DEF_CMD_CODES,
    parameter logic [N_CMD-1:0]   STICKY_MASK = DEF_STICKY_MASK,
    parameter int                 TIMEOUT     = 0,
    parameter int                 CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             arm,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [N_CMD-1:0] cmd_pulse,
    output logic [N_CMD-1:0] cmd_level,
    output logic             unknown_err,
    output logic [2:0]       last_cmd,
    output logic [CNT_W-1:0] cmd_cnt
);

    localparam int TW = timer_width(TIMEOUT);

    logic             accept;
    logic             hit;
    logic [2:0]       idx;
    logic [N_CMD-1:0] sel;
    logic [N_CMD-1:0] pulse_sel;
    logic             pulse_evt;
    logic             sticky_clr;
    logic [N_CMD-1:0] level_w;

    logic [N_CMD-1:0] pulse_q, pulse_d;
    logic             err_q, err_d;
    logic [2:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign accept = rx_valid & enable;

    // Priority match encoder: the lowest channel index wins on duplicate codes
    always_comb begin
        sel = '0;
        idx = '0;
        hit = 1'b0;
        for (int i = 0; i < N_CMD; i++) begin
            if (!hit && rx_data == CMD_CODES[8*i +: 8]) begin
                sel[i] = 1'b1;
                idx    = 3'(i);
                hit    = 1'b1;
            end
        end
    end

    assign pulse_sel  = sel & ~STICKY_MASK;
    assign pulse_evt  = accept & (|pulse_sel);
    // A pulse event ends the ready phase, as does leaving play or multiplayer mode
    assign sticky_clr = ~arm | ~enable | pulse_evt;

    // Next values for the pulse/error strobes, last index and saturating counter
    always_comb begin
        pulse_d = accept ? pulse_sel : '0;
        err_d   = accept & ~hit;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (accept && hit) begin
            last_d = idx;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= '0;
            err_q   <= 1'b0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            pulse_q <= pulse_d;
            err_q   <= err_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar g = 0; g < N_CMD; g++) begin : g_chan
        if (STICKY_MASK[g]) begin : g_sticky
            logic          held;
            logic          set_w;
            logic          reload_w;
            logic [TW-1:0] timer_unused;

            assign set_w    = accept & arm & sel[g] & ~held;
            assign reload_w = accept & arm & sel[g] & held;

            sticky_timer #(
                .TIMEOUT (TIMEOUT)
            ) u_timer (
                .clk    (clk),
                .rst    (rst),
                .set    (set_w),
                .clr    (sticky_clr),
                .reload (reload_w),
                .held   (held),
                .timer  (timer_unused)
            );

            assign level_w[g] = held;
        end else begin : g_pulse
            assign level_w[g] = 1'b0;
        end
    end

    assign cmd_pulse   = pulse_q;
    assign cmd_level   = level_w;
    assign unknown_err = err_q;
    assign last_cmd    = last_q;
    assign cmd_cnt     = cnt_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: default build (no expiry, 8-bit count) and a
// TIMEOUT=16 / CNT_W=2 build. Stimulus pushes hand-computed expected outputs; a monitor
// pops and compares them on the falling edge of the cycle they are due.
module tb_uart_cmd_decoder;
    import uart_cmd_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: default parameters
    logic       rst_a, en_a, arm_a, vld_a;
    logic [7:0] dat_a;
    logic [3:0] pulse_a, level_a;
    logic       err_a;
    logic [2:0] last_a;
    logic [7:0] cnt_a;

    // DUT B: TIMEOUT=16, CNT_W=2
    logic       rst_b, en_b, arm_b, vld_b;
    logic [7:0] dat_b;
    logic [3:0] pulse_b, level_b;
    logic       err_b;
    logic [2:0] last_b;
    logic [1:0] cnt_b;

    uart_cmd_decoder dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .arm(arm_a),
        .rx_data(dat_a), .rx_valid(vld_a),
        .cmd_pulse(pulse_a), .cmd_level(level_a), .unknown_err(err_a),
        .last_cmd(last_a), .cmd_cnt(cnt_a)
    );

    uart_cmd_decoder #(.TIMEOUT(16), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .arm(arm_b),
        .rx_data(dat_b), .rx_valid(vld_b),
        .cmd_pulse(pulse_b), .cmd_level(level_b), .unknown_err(err_b),
        .last_cmd(last_b), .cmd_cnt(cnt_b)
    );

    typedef struct {
        int         due;
        int         dut;
        string      name;
        logic [3:0] p;
        logic [3:0] l;
        logic       e;
        logic [2:0] last;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    localparam logic [7:0] L = CMD_LOST;
    localparam logic [7:0] R = CMD_READY;
    localparam logic [7:0] W = CMD_WIN;
    localparam logic [7:0] P = CMD_PAUSE;

    // Drive one cycle of inputs to one DUT and queue the outputs expected on the next cycle
    task automatic step(input int d, input logic r, input logic en, input logic am,
                        input logic vl, input logic [7:0] dat, input string nm,
                        input logic [3:0] ep, input logic [3:0] el, input logic ee,
                        input logic [2:0] elast, input logic [7:0] ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        if (d == 0) begin
            rst_a = r; en_a = en; arm_a = am; vld_a = vl; dat_a = dat; vld_b = 1'b0;
        end else begin
            rst_b = r; en_b = en; arm_b = am; vld_b = vl; dat_b = dat; vld_a = 1'b0;
        end
        e.due = cyc + 1; e.dut = d; e.name = nm;
        e.p = ep; e.l = el; e.e = ee; e.last = elast; e.cnt = ecnt;
        sb.push_back(e);
    endtask

    // Monitor: compare every queued expectation in the cycle it falls due
    initial begin
        exp_t       e;
        logic [3:0] ap, al;
        logic       ae;
        logic [2:0] alast;
        logic [7:0] acnt;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                if (e.dut == 0) begin
                    ap = pulse_a; al = level_a; ae = err_a; alast = last_a; acnt = cnt_a;
                end else begin
                    ap = pulse_b; al = level_b; ae = err_b; alast = last_b; acnt = {6'b0, cnt_b};
                end
                checks++;
                if (ap === e.p && al === e.l && ae === e.e && alast === e.last && acnt === e.cnt
                    && e.due == cyc) begin
                    passes++;
                end else begin
                    $display("FAIL %s dut%0d cyc%0d: got pulse=%b level=%b err=%b last=%0d cnt=%0d, want pulse=%b level=%b err=%b last=%0d cnt=%0d",
                             e.name, e.dut, cyc, ap, al, ae, alast, acnt, e.p, e.l, e.e, e.last, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

    initial begin
        rst_a = 1'b1; en_a = 1'b0; arm_a = 1'b0; vld_a = 1'b0; dat_a = 8'h00;
        rst_b = 1'b1; en_b = 1'b0; arm_b = 1'b0; vld_b = 1'b0; dat_b = 8'h00;

        // ---------------- DUT A: default build, levels never expire ----------------
        step(0, 1, 0, 0, 0, 8'h00, "a_reset",        4'b0000, 4'b0000, 0, 0, 0);
        step(0, 1, 0, 0, 0, 8'h00, "a_reset2",       4'b0000, 4'b0000, 0, 0, 0);
        step(0, 0, 1, 1, 0, 8'h00, "a_idle",         4'b0000, 4'b0000, 0, 0, 0);
        step(0, 0, 1, 1, 1, R,     "t1_ready_set",   4'b0000, 4'b0010, 0, 1, 1);
        for (int k = 0; k < 3; k++)
            step(0, 0, 1, 1, 0, 8'h00, "t1_ready_hold", 4'b0000, 4'b0010, 0, 1, 1);
        step(0, 0, 1, 1, 1, L,     "t2_lost_pulse",  4'b0001, 4'b0000, 0, 0, 2);
        step(0, 0, 1, 1, 0, 8'h00, "t2_pulse_end",   4'b0000, 4'b0000, 0, 0, 2);
        step(0, 0, 1, 1, 1, 8'h41, "t4_unknown",     4'b0000, 4'b0000, 1, 0, 2);
        step(0, 0, 1, 1, 0, 8'h00, "t4_err_end",     4'b0000, 4'b0000, 0, 0, 2);
        step(0, 0, 0, 1, 1, 8'h41, "t4_unknown_dis", 4'b0000, 4'b0000, 0, 0, 2);
        step(0, 0, 0, 1, 1, L,     "t4_lost_dis",    4'b0000, 4'b0000, 0, 0, 2);
        step(0, 0, 1, 1, 1, W,     "win_pulse",      4'b0100, 4'b0000, 0, 2, 3);
        step(0, 0, 1, 1, 1, P,     "pause_pulse",    4'b1000, 4'b0000, 0, 3, 4);
        step(0, 0, 1, 0, 1, R,     "ready_unarmed",  4'b0000, 4'b0000, 0, 1, 5);
        step(0, 0, 1, 1, 1, R,     "t5_ready_set",   4'b0000, 4'b0010, 0, 1, 6);
        step(0, 0, 1, 0, 1, R,     "t5_arm_fall",    4'b0000, 4'b0000, 0, 1, 7);
        step(0, 0, 1, 1, 1, R,     "t5_ready_again", 4'b0000, 4'b0010, 0, 1, 8);
        step(0, 0, 0, 1, 0, 8'h00, "t5_enable_low",  4'b0000, 4'b0000, 0, 1, 8);
        step(0, 0, 0, 1, 1, R,     "t5_en_low_rx",   4'b0000, 4'b0000, 0, 1, 8);
        step(0, 0, 1, 1, 1, W,     "a_win_again",    4'b0100, 4'b0000, 0, 2, 9);
        step(0, 1, 1, 1, 1, R,     "a_rst_mid",      4'b0000, 4'b0000, 0, 0, 0);

        // ---------------- DUT B: TIMEOUT=16, CNT_W=2 ----------------
        step(1, 1, 0, 0, 0, 8'h00, "b_reset",        4'b0000, 4'b0000, 0, 0, 0);
        step(1, 1, 0, 0, 0, 8'h00, "b_reset2",       4'b0000, 4'b0000, 0, 0, 0);
        // single 'R': high for 16 cycles after receipt, then low
        step(1, 0, 1, 1, 1, R,     "t3a_ready",      4'b0000, 4'b0010, 0, 1, 1);
        for (int k = 1; k <= 17; k++)
            step(1, 0, 1, 1, 0, 8'h00, "t3a_expiry", 4'b0000, (k <= 15) ? 4'b0010 : 4'b0000, 0, 1, 1);
        // re-send at +10: held to +26
        for (int k = 0; k <= 27; k++)
            step(1, 0, 1, 1, (k == 0 || k == 10), (k == 0 || k == 10) ? R : 8'h00, "t3b_resend",
                 4'b0000, (k <= 25) ? 4'b0010 : 4'b0000, 0, 1, (k < 10) ? 8'd2 : 8'd3);
        // re-send exactly on the last held cycle: reload wins; counter stays saturated
        for (int k = 0; k <= 33; k++)
            step(1, 0, 1, 1, (k == 0 || k == 16), (k == 0 || k == 16) ? R : 8'h00, "t3c_reload_vs_expiry",
                 4'b0000, (k <= 31) ? 4'b0010 : 4'b0000, 0, 1, 3);
        // saturation after reset, then reset in the middle of a burst
        step(1, 1, 1, 1, 0, 8'h00, "t6_rst",         4'b0000, 4'b0000, 0, 0, 0);
        step(1, 0, 1, 1, 1, L,     "t6_cmd1",        4'b0001, 4'b0000, 0, 0, 1);
        step(1, 0, 1, 1, 1, W,     "t6_cmd2",        4'b0100, 4'b0000, 0, 2, 2);
        step(1, 0, 1, 1, 1, P,     "t6_cmd3",        4'b1000, 4'b0000, 0, 3, 3);
        step(1, 0, 1, 1, 1, R,     "t6_cmd4_sat",    4'b0000, 4'b0010, 0, 1, 3);
        step(1, 0, 1, 1, 1, L,     "t6_cmd5_sat",    4'b0001, 4'b0000, 0, 0, 3);
        step(1, 0, 1, 1, 1, R,     "t6_burst_r",     4'b0000, 4'b0010, 0, 1, 3);
        step(1, 1, 1, 1, 1, W,     "t6_rst_mid",     4'b0000, 4'b0000, 0, 0, 0);
        step(1, 0, 1, 1, 0, 8'h00, "t6_after_rst",   4'b0000, 4'b0000, 0, 0, 0);
        step(1, 0, 1, 1, 1, R,     "t6_restart",     4'b0000, 4'b0010, 0, 1, 1);

        @(posedge clk);
        #1;
        vld_a = 1'b0; vld_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
